// File: rtl/cpu_pkg.sv
// Shared types and sizes for the single-cycle RISC-V core and its boot loader.
// The state enum is used by the instruction-memory boot loader FSM.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles four accepted bytes into a little-endian word; word is valid while word_last is high.
// Zero latency on the final byte; never stalls, the caller gates accept.
module byte_packer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            accept,
    input  logic [7:0]      byte_dat,
    output logic [XLEN-1:0] word,
    output logic            word_last
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;

    always_comb begin
        lane_d = lane_q;
        asm_d  = asm_q;
        if (clr) begin
            lane_d = 2'd0;
        end else if (accept) begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
                2'd0:    asm_d[7:0]   = byte_dat;
                2'd1:    asm_d[15:8]  = byte_dat;
                2'd2:    asm_d[23:16] = byte_dat;
                default: asm_d        = asm_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            asm_q  <= 24'd0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

    // The top byte bypasses the register so the word is complete in the accepting cycle.
    assign word_last = accept && (lane_q == 2'd3);
    assign word      = {byte_dat, asm_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory and holds the CPU
// in reset until a complete image is written; one bubble per word while the write is issued.
module imem_boot_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [15:0]       len_q, len_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    logic              xfer;
    logic              idle_like;
    logic              more_words;
    logic              bad_len;
    logic [15:0]       len_hdr;
    logic              word_last;
    logic [XLEN-1:0]   word;

    assign xfer       = byte_valid && byte_ready;
    assign idle_like  = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
    assign len_hdr    = {byte_data, len_q[7:0]};
    assign bad_len    = (len_hdr == 16'd0) || (len_hdr > 16'(DEPTH));
    assign more_words = (17'(cnt_q) + 17'd1) < {1'b0, len_q};

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start && idle_like),
        .accept    (xfer && (state_q == DATA)),
        .byte_dat  (byte_data),
        .word      (word),
        .word_last (word_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = LEN_LO;
            LEN_LO:          if (xfer) state_d = LEN_HI;
            LEN_HI:          if (xfer) state_d = bad_len ? ERR : DATA;
            DATA:            if (word_last) state_d = WRITE;
            WRITE:           state_d = more_words ? DATA : DONE;
            default:         state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
        mem_we     = (state_q == WRITE);
        busy       = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == WRITE);
        done       = (state_q == DONE);
        err        = (state_q == ERR);
        cpu_hold   = (state_q != DONE);
    end

    // The counter only advances when another word follows, so it stays within DEPTH-1.
    always_comb begin
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start && idle_like) begin
            cnt_d = '0;
        end
        if ((state_q == LEN_LO) && xfer) begin
            len_d = {8'h00, byte_data};
        end
        if ((state_q == LEN_HI) && xfer) begin
            len_d = len_hdr;
        end
        if (word_last) begin
            addr_d  = XLEN'({cnt_q, 2'b00});
            wdata_d = word;
        end
        if ((state_q == WRITE) && more_words) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            len_q   <= 16'd0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for the instruction-memory boot loader.
module tb_imem_boot_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          failures = 0;
    int          nwr = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          final_pending = 0;
    bit          chk_done_next = 0;
    logic [31:0] pa, pd;

    imem_boot_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents is matched against the model's queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk_done_next = 0;
        end else begin
            if (chk_done_next) begin
                chk("done_one_cycle_after_last_write", {29'd0, done, cpu_hold, busy}, 32'h4);
                chk_done_next = 0;
            end
            if (mem_we) begin
                nwr++;
                chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    pa = exp_addr.pop_front();
                    pd = exp_data.pop_front();
                    chk("write_addr", mem_addr, pa);
                    chk("write_data", mem_wdata, pd);
                    if (exp_addr.size() == 0 && final_pending) begin
                        chk_done_next = 1;
                        final_pending = 0;
                    end
                end
            end
        end
    end

    // Reference model: decode the image from the stream rules; returns 1 for a bad header.
    function automatic bit model_load(input bq_t b);
        int n;
        n = int'(b[0]) | (int'(b[1]) << 8);
        if (n == 0 || n > 64) return 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(32'(k * 4));
            exp_data.push_back({b[2+4*k+3], b[2+4*k+2], b[2+4*k+1], b[2+4*k]});
        end
        final_pending = 1;
        return 1'b0;
    endfunction

    function automatic bq_t build_img(input int n_hdr, input int n_words);
        bq_t b;
        b.push_back(8'(n_hdr));
        b.push_back(8'(n_hdr >> 8));
        for (int i = 0; i < n_words * 4; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input bq_t b, input int gap_pct, input int start_at, input int abort_at);
        int idx = 0;
        int guard = 0;
        bit started = 0;
        bit acc;
        while (idx < b.size() && idx != abort_at) begin
            byte_valid = ($urandom_range(99) >= gap_pct);
            byte_data  = byte_valid ? b[idx] : 8'($urandom);
            start      = (idx == start_at) && !started;
            if (start) started = 1;
            acc = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (acc) idx++;
            guard++;
            if (guard > 20000) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: accepted %0d of %0d bytes", idx, b.size());
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input bit exp_err);
        int g = 0;
        while (!(done || err) && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({name, "_done"}, {31'd0, done}, {31'd0, !exp_err});
        chk({name, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, exp_err});
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({name, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({name, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({name, "_mem_addr"}, mem_addr, 32'd0);
        chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({name, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_done"}, {31'd0, done}, 32'd0);
        chk({name, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic run_load(input string name, input bq_t img, input int gap_pct,
                            input int start_at, input int exp_words);
        bit e;
        int w0;
        e  = model_load(img);
        w0 = nwr;
        do_start();
        chk({name, "_busy_after_start"}, {30'd0, busy, cpu_hold}, 32'h3);
        chk({name, "_flags_cleared"}, {30'd0, done, err}, 32'h0);
        send(img, gap_pct, start_at, -1);
        wait_end(name, e);
        chk({name, "_write_count"}, 32'(nwr - w0), 32'(exp_words));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] nom[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                                8'h93, 8'h05, 8'hB0, 8'h00};
        logic [7:0] dbf[6]  = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        bq_t img;
        bit  e;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (nom[i]) img.push_back(nom[i]);
        run_load("nominal", img, 0, -1, 2);

        run_load("len0", build_img(0, 0), 0, -1, 0);
        run_load("len65", build_img(65, 0), 0, -1, 0);
        run_load("len64", build_img(64, 64), 0, -1, 64);
        run_load("gaps", build_img(3, 3), 50, -1, 3);
        run_load("start_busy", build_img(3, 3), 20, 7, 3);

        img = build_img(4, 4);
        e = model_load(img);
        do_start();
        send(img, 0, -1, 12);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        exp_addr.delete();
        exp_data.delete();
        final_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_load("after_reset", build_img(3, 3), 30, -1, 3);

        img.delete();
        foreach (dbf[i]) img.push_back(dbf[i]);
        run_load("reload", img, 0, -1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
